// File: rtl/syn_current_integrator.sv
// Synaptic current integrator feeding one LIF neuron.
// Each presynaptic input has a programmable weight. Spikes that arrive during a
// timestep are latched, and their weights are summed once per timestep. Before
// that sum is added, isyn is reduced by a shift-based exponential leak.

// Per-input lane: holds one weight and gates it onto the sum when the input fired.
module syn_current_lane #(
  parameter int W_WIDTH  = 8,
  parameter int AW       = 3,
  parameter int LANE_IDX = 0,
  parameter int W_INIT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic               active,
  output logic [W_WIDTH-1:0] contrib
);
  localparam logic [AW-1:0]      MY_ADDR = AW'(LANE_IDX);
  localparam logic [W_WIDTH-1:0] W_RST   = W_WIDTH'(W_INIT);

  logic [W_WIDTH-1:0] weight;

  // Weight register. Writes are not gated by ena. An update in the same cycle
  // sees the old value, because the sum reads the pre-edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             weight <= W_RST;
    else if (wr_en && (wr_addr == MY_ADDR)) weight <= wr_data;
  end

  assign contrib = active ? weight : '0;
endmodule

module syn_current_integrator #(
  parameter int N_IN        = 8,
  parameter int W_WIDTH     = 8,
  parameter int DECAY_SHIFT = 2,
  parameter int TICK_DIV    = 4,
  parameter int W_INIT      = 0,
  localparam int AW         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_IN-1:0]    spikes_in,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] isyn,
  output logic               tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = W_WIDTH + AW;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW:0]   ISYN_MAX  = (SW+1)'({W_WIDTH{1'b1}});

  logic [CW-1:0]                   cnt;
  logic [N_IN-1:0]                 pend;
  logic [N_IN-1:0]                 active;
  logic [N_IN-1:0][W_WIDTH-1:0]    contrib;
  logic                            upd;
  logic [SW-1:0]                   sum;
  logic [W_WIDTH-1:0]              decayed;
  logic [SW:0]                     nxt_wide;
  logic [W_WIDTH-1:0]              isyn_nxt;

  assign upd = ena && (cnt == TICK_LAST);

  // Spikes arriving on the update cycle itself still count in this timestep.
  assign active = pend | spikes_in;

  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    syn_current_lane #(
      .W_WIDTH (W_WIDTH),
      .AW      (AW),
      .LANE_IDX(g),
      .W_INIT  (W_INIT)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .active (active[g]),
      .contrib(contrib[g])
    );
  end

  // Weighted sum is sized so that all N_IN lanes at full weight cannot wrap.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + SW'(contrib[i]);
  end

  // Leak first, then add the sum, then clamp to full scale.
  // isyn - (isyn >> k) can never go below zero.
  always_comb begin
    decayed  = isyn - (isyn >> DECAY_SHIFT);
    nxt_wide = (SW+1)'(decayed) + (SW+1)'(sum);
    isyn_nxt = (nxt_wide > ISYN_MAX) ? '1 : nxt_wide[W_WIDTH-1:0];
  end

  // Timestep counter, spike latch, current register and tick pulse.
  // Everything except the weights freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= '0;
      isyn <= '0;
      tick <= 1'b0;
    end else begin
      tick <= upd;
      if (upd) begin
        cnt  <= '0;
        pend <= '0;
        isyn <= isyn_nxt;
      end else if (ena) begin
        cnt  <= cnt + CW'(1);
        pend <= pend | spikes_in;
      end
    end
  end
endmodule

// File: tb/tb_syn_current_integrator.sv
// Directed bench for syn_current_integrator with the default parameters
// (N_IN=8, W_WIDTH=8, DECAY_SHIFT=2, TICK_DIV=4, W_INIT=0).
// The expected values are worked out by hand from the leak/sum/saturate rule.
module tb_syn_current_integrator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] spikes_in = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] isyn;
  logic       tick;

  int errs   = 0;
  int checks = 0;

  syn_current_integrator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spikes_in(spikes_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .isyn     (isyn),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in this bench.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock edge, then settle 1ns past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until tick is seen, with a bounded wait. Check how many edges that took.
  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 16);
    chk(tag, n, exp_n);
  endtask

  initial begin
    int decay_exp [4] = '{75, 57, 43, 33};

    // ---- reset state and first tick after release ----
    #12;
    chk("rst_isyn", isyn, 0);
    chk("rst_tick", tick, 0);
    step();
    rst_n = 1'b1;
    ena   = 1'b1;
    wait_tick("first_tick_lat", 4);
    chk("first_tick_isyn", isyn, 0);

    // ---- single spike and decay to the floor ----
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd100;
    step();
    wr_en = 1'b0; spikes_in = 8'h01;
    step();
    spikes_in = 8'h00;
    wait_tick("spk_tick_lat", 2);
    chk("spk_isyn", isyn, 100);
    foreach (decay_exp[k]) begin
      wait_tick("decay_lat", 4);
      chk("decay_isyn", isyn, decay_exp[k]);
    end
    for (int k = 0; k < 11; k++) wait_tick("floor_lat", 4);
    chk("floor_isyn", isyn, 3);
    wait_tick("floor_lat", 4);
    chk("floor_hold", isyn, 3);

    // ---- asynchronous reset in the middle of a timestep ----
    spikes_in = 8'h01;
    step();
    spikes_in = 8'h00;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_isyn", isyn, 0);
    chk("midrst_tick", tick, 0);
    step();
    rst_n = 1'b1;
    wait_tick("midrst_lat", 4);
    chk("midrst_after", isyn, 0);

    // ---- latching, duplicate spikes, same-cycle spike on the update cycle ----
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd20; spikes_in = 8'h02;
    step();
    wr_addr = 3'd2; wr_data = 8'd10;
    step();
    wr_en = 1'b0;
    step();
    spikes_in = 8'h04;
    step();
    chk("latch_tick", tick, 1);
    chk("latch_isyn", isyn, 30);
    spikes_in = 8'h00;
    wait_tick("latch_lat", 4);
    chk("pend_cleared", isyn, 23);

    // ---- saturation ----
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'd200;
      step();
    end
    wr_en = 1'b0;
    spikes_in = 8'hFF;
    repeat (4) step();
    chk("sat_tick", tick, 1);
    chk("sat_isyn", isyn, 255);
    spikes_in = 8'h00;
    wait_tick("sat_lat", 4);
    chk("sat_decay", isyn, 192);

    // ---- write/update collision ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_tick("coll_rst_lat", 4);
    chk("coll_rst_isyn", isyn, 0);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'd50;
    step();
    wr_en = 1'b0;
    repeat (2) step();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'd5; spikes_in = 8'h08;
    step();
    chk("coll_tick", tick, 1);
    chk("coll_old_w", isyn, 50);
    wr_en = 1'b0; spikes_in = 8'h00;
    repeat (3) step();
    spikes_in = 8'h08;
    step();
    chk("coll_new_w", isyn, 43);
    spikes_in = 8'h00;

    // ---- enable gating, held with the counter on the update count ----
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'd100;
    step();
    wr_en = 1'b0; spikes_in = 8'h08;
    step();
    spikes_in = 8'h00;
    step();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spikes_in = (i % 2 == 1) ? 8'hFF : 8'h00;
      if (i == 5) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'd7;
      end else begin
        wr_en = 1'b0;
      end
      step();
      chk("gate_tick", tick, 0);
      chk("gate_isyn", isyn, 43);
    end
    spikes_in = 8'h00; wr_en = 1'b0; ena = 1'b1;
    step();
    chk("resume_tick", tick, 1);
    chk("resume_isyn", isyn, 40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
